// File: rtl/irq_responder_if.sv
// ============================================================================
// irq_responder_if : request, system-register and PC-redirect signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface irq_responder_if #(
    parameter int DBITS = 32
);
    logic             irq;
    logic [3:0]       idn;
    logic [DBITS-1:0] nxtPc;
    logic             instValid;
    logic             wrEn;
    logic [1:0]       wrIndex;
    logic [DBITS-1:0] wrData;
    logic [1:0]       rdIndex;
    logic [DBITS-1:0] rdData;
    logic             reti;
    logic             pcIntrSel;
    logic [DBITS-1:0] pcAddrOut;
    logic             ieOut;
    logic             inIsr;

    modport master (
        output irq, idn, nxtPc, instValid, wrEn, wrIndex, wrData, rdIndex, reti,
        input  rdData, pcIntrSel, pcAddrOut, ieOut, inIsr
    );

    modport slave (
        input  irq, idn, nxtPc, instValid, wrEn, wrIndex, wrData, rdIndex, reti,
        output rdData, pcIntrSel, pcAddrOut, ieOut, inIsr
    );
endinterface

`default_nettype wire

// File: rtl/irq_responder.sv
// ============================================================================
// irq_responder : CPU interrupt acceptance, owns IHA/IRA/IDN/PCS, redirects PC
// Option macro IRQ_SYNC_EN adds a two-flop synchronizer on irq/idn.  Rev 1.0
// ============================================================================
`default_nettype none

module irq_responder #(
    parameter int               DBITS     = 32,
    parameter logic [DBITS-1:0] IHA_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    irq_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TAKE   = 2'd1,
        S_INSVC  = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t           state;
    logic [DBITS-1:0] iha_reg;
    logic [DBITS-1:0] ira_reg;
    logic [3:0]       idn_reg;
    logic             ie_reg;
    logic             oie_reg;

    logic             irq_s;
    logic [3:0]       idn_s;
    logic             take;

`ifdef IRQ_SYNC_EN
    // irq and idn share stages so the captured device number matches the request
    logic       irq_m;
    logic       irq_q;
    logic [3:0] idn_m;
    logic [3:0] idn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_m <= 1'b0;
            irq_q <= 1'b0;
            idn_m <= 4'hF;
            idn_q <= 4'hF;
        end else begin
            irq_m <= bus.irq;
            irq_q <= irq_m;
            idn_m <= bus.idn;
            idn_q <= idn_m;
        end
    end

    assign irq_s = irq_q;
    assign idn_s = idn_q;
`else
    assign irq_s = bus.irq;
    assign idn_s = bus.idn;
`endif

    assign take = (state == S_IDLE) && irq_s && ie_reg && bus.instValid;

    // Hardware updates come after the software write so they win on collisions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            iha_reg <= IHA_RESET;
            ira_reg <= '0;
            idn_reg <= 4'hF;
            ie_reg  <= 1'b0;
            oie_reg <= 1'b0;
        end else begin
            if (bus.wrEn) begin
                case (bus.wrIndex)
                    2'd0: iha_reg <= bus.wrData;
                    2'd1: ira_reg <= bus.wrData;
                    2'd2: idn_reg <= bus.wrData[3:0];
                    default: begin
                        ie_reg  <= bus.wrData[0];
                        oie_reg <= bus.wrData[1];
                    end
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (take) begin
                        state   <= S_TAKE;
                        idn_reg <= idn_s;
                        oie_reg <= ie_reg;
                        ie_reg  <= 1'b0;
                    end
                end
                S_TAKE: begin
                    state   <= S_INSVC;
                    ira_reg <= bus.nxtPc;
                end
                S_INSVC: begin
                    if (bus.reti) begin
                        state  <= S_RETURN;
                        ie_reg <= oie_reg;
                    end
                end
                S_RETURN: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset drops a redirect at once
    always_comb begin
        bus.pcIntrSel = 1'b0;
        bus.pcAddrOut = '0;
        bus.inIsr     = 1'b0;
        case (state)
            S_TAKE: begin
                bus.pcIntrSel = 1'b1;
                bus.pcAddrOut = iha_reg;
                bus.inIsr     = 1'b1;
            end
            S_INSVC: bus.inIsr = 1'b1;
            S_RETURN: begin
                bus.pcIntrSel = 1'b1;
                bus.pcAddrOut = ira_reg;
            end
            default: ;
        endcase
    end

    assign bus.ieOut = ie_reg;

    always_comb begin
        bus.rdData = '0;
        case (bus.rdIndex)
            2'd0:    bus.rdData = iha_reg;
            2'd1:    bus.rdData = ira_reg;
            2'd2:    bus.rdData = {{(DBITS-4){1'b0}}, idn_reg};
            default: bus.rdData = {{(DBITS-2){1'b0}}, oie_reg, ie_reg};
        endcase
    end
endmodule

`default_nettype wire

// File: doc/irq_responder.md
# irq_responder

CPU-side interrupt acceptance unit: the receiving end of the IO controller's `IRQ`/`IDN` request lines. It owns the system registers IHA, IRA, IDN and PCS. It decides at instruction boundaries whether to take a pending request and redirects the PC to the handler. On `reti` it restores the interrupted PC and the prior enable state. It sits between the IO controller outputs and the PC input mux (`pcIntrSel`/`pcAddrOut` drive the interrupt PC mux).

## Interface
- `DBITS`, 32, data/address width.
- `IHA_RESET`, 32'h0, reset value of the handler address register IHA.
- `clk` in 1: CPU clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `irq` in 1: level interrupt request from the IO controller.
- `idn` in 4: requesting device number, valid while `irq`=1.
- `nxtPc` in DBITS: address the PC would load this cycle without redirect.
- `instValid` in 1: the current cycle holds a committing instruction, not a bubble.
- `wrEn` in 1, `wrIndex` in 2, `wrData` in DBITS: system register write. Index map: 0=IHA, 1=IRA, 2=IDN, 3=PCS.
- `rdIndex` in 2: system register read select.
- `rdData` out DBITS: combinational read. PCS reads as {30'b0, OIE, IE}; IDN is zero-extended.
- `reti` in 1: return-from-interrupt strobe from the decoder.
- `pcIntrSel` out 1: 1 = PC mux takes `pcAddrOut`.
- `pcAddrOut` out DBITS: redirect target; 0 when `pcIntrSel`=0.
- `ieOut` out 1: PCS.IE.
- `inIsr` out 1: 1 in states TAKE and INSVC.

## Operation
- State machine:
  - IDLE -> TAKE when `irq_s` & IE & `instValid`. `irq_s` is `irq` after the optional synchronizer.
  - TAKE -> INSVC unconditionally.
  - INSVC -> RETURN on `reti`.
  - RETURN -> IDLE unconditionally.
- Take edge (IDLE->TAKE):
  - IDN <= `idn_s`.
  - OIE <= IE, IE <= 0.
- TAKE cycle:
  - `pcIntrSel`=1, `pcAddrOut`=IHA, using the post-edge register value.
  - The instruction in this cycle commits normally.
  - At the end edge, IRA <= `nxtPc`.
- INSVC: no further interrupts are accepted, even if software sets IE. Nesting is not supported.
- Reti edge (INSVC->RETURN): IE <= OIE.
- RETURN cycle: `pcIntrSel`=1, `pcAddrOut`=IRA; next state IDLE.
- `reti` in IDLE, TAKE or RETURN is ignored.
- Software writes apply in any state, with these priorities:
  - Take edge vs. PCS write: the take update wins for IE/OIE.
  - Reti edge vs. PCS write: the reti restore wins for IE.
  - TAKE-end edge vs. IRA write: the hardware capture wins.
  - IHA and IDN writes are never blocked. An IDN write on the take edge loses to the hardware capture.
- `irq` dropping after the take edge has no effect; the request was already captured.

## Timing
- Reset (`rst`=0, async) state:
  - State=IDLE, IHA=`IHA_RESET`, IRA=0, IDN=4'hF, IE=0, OIE=0.
  - `pcIntrSel`=0, `pcAddrOut`=0, `ieOut`=0, `inIsr`=0.
- Reset mid-TAKE or mid-RETURN aborts the redirect immediately, because outputs are decoded from state.
- Request latency without synchronizer: `irq` high at edge N (conditions true) -> `pcIntrSel`=1 during cycle N+1 -> handler fetch at edge N+2.
- Return latency: `reti` at edge M -> `pcIntrSel`=1 during cycle M+1 -> IRA fetched at edge M+2.
- `rdData` is combinational from `rdIndex` with zero cycles of latency. It reflects pre-edge register values.

## Configuration
- `IRQ_SYNC_EN` defined:
  - `irq` and `idn` pass through a two-flop synchronizer (reset to 0 / 4'hF) before use, because the IO controller runs on a different clock.
  - Take latency grows by 2 cycles.
  - `idn_s` is sampled from the same synchronizer stage as `irq_s`.
- `IRQ_SYNC_EN` undefined: `irq_s`=`irq` and `idn_s`=`idn` are used directly.

## Test plan
- Basic take (no sync):
  - Setup: IHA=32'h200, IE=1, IDLE, `instValid`=1, `nxtPc`=32'h48.
  - Stimulus: `irq`=1, `idn`=2.
  - Required: next cycle `pcIntrSel`=1, `pcAddrOut`=32'h200; then IRA=32'h48, IDN=2, IE=0, OIE=1, `inIsr`=1.
- Gating:
  - IE=0 with `irq`=1 for 10 cycles -> `pcIntrSel` stays 0.
  - IE=1 with `instValid`=0 -> no take until `instValid`=1.
- Return: from INSVC with IRA=32'h48, pulse `reti` -> next cycle `pcAddrOut`=32'h48, `pcIntrSel`=1, IE=1; then IDLE, `inIsr`=0.
- Priorities:
  - Write PCS=32'h0 on the take edge -> IE=0, OIE=1 (take wins).
  - Write PCS=32'h0 on the reti edge -> IE=OIE.
- Reset mid-TAKE: drop `rst` during TAKE -> `pcIntrSel`=0 at once; all registers at reset values; `rdData` for PCS=0.
- `IRQ_SYNC_EN` build: the basic-take stimulus gives `pcIntrSel`=1 exactly 3 cycles after `irq` rises.
